// File: rtl/tlb_pkg.sv
// tlb_pkg: shared op encodings, entry layout, and scheduler states for the TLB maintenance path.
package tlb_pkg;
  localparam int ENTRY_W = 89;
  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD = 3'd1;
  localparam logic [2:0] OP_WR = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV = 3'd4;
  localparam logic [4:0] INV_OP_MAX = 5'd6;
  // Entry layout, msb first: vppn, asid, g, ps, e, then page 0 and page 1 {v, d, mat, plv, ppn}.
  localparam int PPN1_LSB = 0;
  localparam int PLV1_LSB = 20;
  localparam int MAT1_LSB = 22;
  localparam int D1_BIT = 24;
  localparam int V1_BIT = 25;
  localparam int PPN0_LSB = 26;
  localparam int PLV0_LSB = 46;
  localparam int MAT0_LSB = 48;
  localparam int D0_BIT = 50;
  localparam int V0_BIT = 51;
  localparam int E_BIT = 52;
  localparam int PS_LSB = 53;
  localparam int G_BIT = 59;
  localparam int ASID_LSB = 60;
  localparam int VPPN_LSB = 70;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SRCH_RES, S_RESP} state_e;
endpackage

// File: rtl/tlb_s1_arb.sv
// tlb_s1_arb: search port 1 mux between data-side translation and TLBSRCH, with data-side stall.
module tlb_s1_arb (
  input  logic        own_i,
  input  logic [18:0] cmd_vppn_i,
  input  logic [9:0]  cmd_asid_i,
  input  logic        mem_req_i,
  input  logic [18:0] mem_vppn_i,
  input  logic        mem_odd_i,
  input  logic [9:0]  mem_asid_i,
  output logic        mem_stall_o,
  output logic        s1_fetch_o,
  output logic [18:0] s1_vppn_o,
  output logic        s1_odd_page_o,
  output logic [9:0]  s1_asid_o
);
  always_comb begin
    s1_fetch_o = own_i | mem_req_i;
    s1_vppn_o = own_i ? cmd_vppn_i : mem_vppn_i;
    s1_odd_page_o = own_i ? 1'b0 : mem_odd_i;
    s1_asid_o = own_i ? cmd_asid_i : mem_asid_i;
    mem_stall_o = own_i & mem_req_i;
  end
endmodule

// File: rtl/tlb_op_sched.sv
// tlb_op_sched: sequences TLB maintenance commands onto the tlb_entry ports and returns one result each.
module tlb_op_sched
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 32,
  parameter int ENTRY_W = tlb_pkg::ENTRY_W,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [IW-1:0]      cmd_index,
  input  logic [ENTRY_W-1:0] cmd_wdata,
  input  logic [4:0]         cmd_inv_op,
  input  logic [9:0]         cmd_asid,
  input  logic [18:0]        cmd_vppn,
  output logic               resp_valid,
  output logic               resp_err,
  output logic               resp_found,
  output logic [IW-1:0]      resp_index,
  output logic [ENTRY_W-1:0] resp_rdata,
  input  logic               mem_req,
  input  logic [18:0]        mem_vppn,
  input  logic               mem_odd,
  input  logic [9:0]         mem_asid,
  output logic               mem_stall,
  output logic               s1_fetch,
  output logic [18:0]        s1_vppn,
  output logic               s1_odd_page,
  output logic [9:0]         s1_asid,
  input  logic               s1_found,
  input  logic [4:0]         s1_index,
  output logic               we,
  output logic [IW-1:0]      w_index,
  output logic [ENTRY_W-1:0] w_data,
  output logic [IW-1:0]      r_index,
  input  logic [ENTRY_W-1:0] r_data,
  output logic               inv_en,
  output logic [4:0]         inv_op,
  output logic [9:0]         inv_asid,
  output logic [18:0]        inv_vpn
);
  state_e state_q;
  logic [2:0] op_q;
  logic [IW-1:0] idx_q;
  logic [ENTRY_W-1:0] wdata_q;
  logic [4:0] inv_op_q;
  logic [9:0] asid_q;
  logic [18:0] vppn_q;
  logic [IW-1:0] fill_ctr_q, fill_ctr_d;
  logic resp_err_q, resp_found_q;
  logic [IW-1:0] resp_index_q;
  logic [ENTRY_W-1:0] resp_rdata_q;
  logic exec, own, inv_ok, bad;
  // Port strobes are gated by reset so an interrupted command never touches tlb_entry.
  always_comb begin
    exec = state_q == S_EXEC && !reset;
    own = exec && op_q == OP_SRCH;
    inv_ok = inv_op_q <= INV_OP_MAX;
    bad = op_q > OP_INV || (op_q == OP_INV && !inv_ok);
    fill_ctr_d = fill_ctr_q + 1'b1;
    we = exec && (op_q == OP_WR || op_q == OP_FILL);
    w_index = !we ? '0 : op_q == OP_FILL ? fill_ctr_q : idx_q;
    w_data = we ? wdata_q : '0;
    r_index = exec && op_q == OP_RD ? idx_q : '0;
    inv_en = exec && op_q == OP_INV && inv_ok;
    inv_op = inv_en ? inv_op_q : '0;
    inv_asid = inv_en ? asid_q : '0;
    inv_vpn = inv_en ? vppn_q : '0;
    cmd_ready = state_q == S_IDLE;
    resp_valid = state_q == S_RESP;
    resp_err = resp_err_q;
    resp_found = resp_found_q;
    resp_index = resp_index_q;
    resp_rdata = resp_rdata_q;
  end
  tlb_s1_arb u_arb (
    .own_i(own),
    .cmd_vppn_i(vppn_q),
    .cmd_asid_i(asid_q),
    .mem_req_i(mem_req),
    .mem_vppn_i(mem_vppn),
    .mem_odd_i(mem_odd),
    .mem_asid_i(mem_asid),
    .mem_stall_o(mem_stall),
    .s1_fetch_o(s1_fetch),
    .s1_vppn_o(s1_vppn),
    .s1_odd_page_o(s1_odd_page),
    .s1_asid_o(s1_asid)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      inv_op_q <= '0;
      asid_q <= '0;
      vppn_q <= '0;
      fill_ctr_q <= '0;
      resp_err_q <= 1'b0;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      fill_ctr_q <= fill_ctr_d;
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          op_q <= cmd_op;
          idx_q <= cmd_index;
          wdata_q <= cmd_wdata;
          inv_op_q <= cmd_inv_op;
          asid_q <= cmd_asid;
          vppn_q <= cmd_vppn;
          resp_err_q <= 1'b0;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= op_q == OP_SRCH ? S_SRCH_RES : S_RESP;
          resp_err_q <= bad;
          if (op_q == OP_FILL) resp_index_q <= fill_ctr_q;
          if (op_q == OP_RD) resp_rdata_q <= r_data;
        end
        S_SRCH_RES: begin
          resp_found_q <= s1_found;
          resp_index_q <= s1_index[IW-1:0];
          state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
